// File: rtl/jt49_seq_pkg.sv
// Shared definitions for the jt49 command sequencer: command layout,
// special opcodes and FSM state encoding.
package jt49_seq_pkg;

  localparam int OP_W  = 4;
  localparam int ARG_W = 8;
  localparam int CMD_W = OP_W + ARG_W;

  localparam logic [OP_W-1:0] OP_END  = 4'hE;
  localparam logic [OP_W-1:0] OP_WAIT = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_WAIT
  } state_t;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [ARG_W-1:0] arg;
  } cmd_t;

endpackage

// File: rtl/jt49_seq_wait.sv
// Loadable down-counter for sequencer waits; decrements only on cen while
// enabled and reports zero and one-remaining.
module jt49_seq_wait #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic         cen,
  output logic         zero,
  output logic         last
);

  logic [W-1:0] count;

  // NOTE: sequential state is assigned with <= only, so every flop samples
  // the pre-edge values of its neighbours regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && cen && count != '0) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);
  assign last = (count == W'(1));

endmodule

// File: rtl/jt49_cmd_seq.sv
// Command-list sequencer and host-priority arbiter driving the jt49 register
// port; all outputs are registered.
module jt49_cmd_seq
  import jt49_seq_pkg::*;
#(
  parameter int AW      = 6,
  parameter int WAIT_SH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cen,
  input  logic             start,
  input  logic             stop,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    cmd_addr,
  input  logic [CMD_W-1:0] cmd_data,
  input  logic             host_wr,
  input  logic [3:0]       host_addr,
  input  logic [7:0]       host_din,
  output logic [3:0]       psg_addr,
  output logic [7:0]       psg_din,
  output logic             psg_wr_n,
  output logic             psg_cs_n
);

  localparam int CNT_W = ARG_W + WAIT_SH;

  state_t            state, state_n;
  cmd_t              cmd;
  logic [AW-1:0]     addr_n;
  logic [CNT_W-1:0]  wait_val;
  logic              done_n;
  logic              seq_wr;
  logic              adv;
  logic              wait_load;
  logic              wait_zero;
  logic              wait_last;
  logic              last_addr;

  assign cmd       = cmd_t'(cmd_data);
  assign wait_val  = CNT_W'(cmd.arg) << WAIT_SH;
  assign last_addr = &cmd_addr;

  jt49_seq_wait #(.W(CNT_W)) u_wait (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (stop),
    .load     (wait_load),
    .load_val (wait_val),
    .en       (state == S_WAIT),
    .cen      (cen),
    .zero     (wait_zero),
    .last     (wait_last)
  );

  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n   = state;
    addr_n    = cmd_addr;
    done_n    = 1'b0;
    seq_wr    = 1'b0;
    adv       = 1'b0;
    wait_load = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_FETCH;
          addr_n  = '0;
        end
      end
      S_FETCH: state_n = S_EXEC;
      S_EXEC: begin
        case (cmd.op)
          OP_END: begin
            done_n  = 1'b1;
            state_n = S_IDLE;
          end
          OP_WAIT: begin
            if (cmd.arg == '0) begin
              adv = 1'b1;
            end else begin
              wait_load = 1'b1;
              state_n   = S_WAIT;
            end
          end
          default: begin
            // The host owns the port this cycle; retry the same command next clk.
            if (!host_wr) begin
              seq_wr = 1'b1;
              adv    = 1'b1;
            end
          end
        endcase
      end
      S_WAIT: begin
        if (wait_zero || (cen && wait_last)) adv = 1'b1;
      end
      default: state_n = S_IDLE;
    endcase

    // Completing the final entry ends the list instead of wrapping the address.
    if (adv) begin
      if (last_addr) begin
        done_n  = 1'b1;
        state_n = S_IDLE;
      end else begin
        addr_n  = cmd_addr + AW'(1);
        state_n = S_FETCH;
      end
    end

    if (stop) begin
      state_n   = S_IDLE;
      addr_n    = cmd_addr;
      done_n    = 1'b0;
      seq_wr    = 1'b0;
      wait_load = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cmd_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      psg_wr_n <= 1'b1;
      psg_addr <= '0;
      psg_din  <= '0;
    end else begin
      state    <= state_n;
      cmd_addr <= addr_n;
      busy     <= (state_n != S_IDLE);
      done     <= done_n;
      psg_wr_n <= !(host_wr || seq_wr);
      if (host_wr) begin
        psg_addr <= host_addr;
        psg_din  <= host_din;
      end else if (seq_wr) begin
        psg_addr <= cmd.op;
        psg_din  <= cmd.arg;
      end
    end
  end

  assign psg_cs_n = psg_wr_n;

endmodule

// File: tb/tb_jt49_cmd_seq.sv
// Self-checking bench for jt49_cmd_seq: directed lists plus randomized lists,
// cen and host traffic, compared cycle-by-cycle against a list-level model.
module tb_jt49_cmd_seq;

  localparam int AW      = 6;
  localparam int WAIT_SH = 2;
  localparam int N       = 1 << AW;
  localparam int MAXC    = 4096;
  localparam int TAIL    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cen = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          host_wr = 1'b0;
  logic [3:0]    host_addr = '0;
  logic [7:0]    host_din = '0;
  logic          busy, done;
  logic [AW-1:0] cmd_addr;
  logic [11:0]   cmd_data;
  logic [3:0]    psg_addr;
  logic [7:0]    psg_din;
  logic          psg_wr_n, psg_cs_n;

  logic [11:0]   mem [N];

  jt49_cmd_seq #(.AW(AW), .WAIT_SH(WAIT_SH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cen       (cen),
    .start     (start),
    .stop      (stop),
    .busy      (busy),
    .done      (done),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .host_wr   (host_wr),
    .host_addr (host_addr),
    .host_din  (host_din),
    .psg_addr  (psg_addr),
    .psg_din   (psg_din),
    .psg_wr_n  (psg_wr_n),
    .psg_cs_n  (psg_cs_n)
  );

  always #5 clk = ~clk;

  // Synchronous command memory: data one clk after address.
  always @(posedge clk) cmd_data <= mem[cmd_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Per-cycle logs of inputs and observed outputs, sampled mid-cycle.
  bit          cen_h  [MAXC];
  bit          host_h [MAXC];
  logic [11:0] host_v [MAXC];
  bit          ow     [MAXC];
  logic [11:0] ov     [MAXC];
  bit          od     [MAXC];
  bit          ob     [MAXC];

  always @(negedge clk) begin
    if (cyc < MAXC) begin
      cen_h[cyc]  = cen;
      host_h[cyc] = host_wr;
      host_v[cyc] = {host_addr, host_din};
      ow[cyc]     = !psg_wr_n;
      ov[cyc]     = {psg_addr, psg_din};
      od[cyc]     = done;
      ob[cyc]     = busy;
    end
  end

  // Expected per-cycle strobe/data/done
  bit          ew [MAXC];
  logic [11:0] ev [MAXC];
  bit          ed [MAXC];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // List-level model: walks the command list using the timing rules
  // (EXEC two clks after start, write visible the clk after EXEC, next EXEC
  // two clks later, waits end on the k-th cen, host strobes stall writes).
  task automatic model(input int s, input int e, input int stop_c);
    int t, c, n, k, a, fin_c;
    bit fin;
    logic [3:0] op;
    logic [7:0] arg;
    for (int i = s; i <= e + 1; i++) begin
      ew[i] = 1'b0;
      ed[i] = 1'b0;
      ev[i] = '0;
    end
    for (int i = s; i < e; i++) begin
      if (host_h[i]) begin
        ew[i+1] = 1'b1;
        ev[i+1] = host_v[i];
      end
    end
    t   = s + 2;
    a   = 0;
    fin = 1'b0;
    while (!fin && t < e) begin
      {op, arg} = mem[a];
      fin_c = -1;
      if (op == 4'hE) begin
        if (t + 1 <= stop_c) ed[t+1] = 1'b1;
        fin = 1'b1;
      end else if (op == 4'hF) begin
        k = int'(arg) << WAIT_SH;
        c = t;
        n = 0;
        while (n < k && c < e) begin
          c++;
          if (cen_h[c]) n++;
        end
        if (n < k) fin = 1'b1;
        else fin_c = c;
      end else begin
        while (host_h[t] && t < e) t++;
        if (t + 1 <= stop_c) begin
          ew[t+1] = 1'b1;
          ev[t+1] = mem[a];
        end
        fin_c = t;
      end
      if (!fin) begin
        if (a == N - 1) begin
          if (fin_c + 1 <= stop_c) ed[fin_c+1] = 1'b1;
          fin = 1'b1;
        end else begin
          a++;
          t = fin_c + 2;
        end
      end
    end
  endtask

  // Drive one list run (start at offset 0), then compare against the model.
  task automatic run_window(input string name, input int len, input int cen_per,
                            input int stop_off, input int host_off, input bit rand_host,
                            input int restart_off);
    int s, e, stop_c;
    bit act;
    s = cyc;
    for (int i = 0; i < len + TAIL; i++) begin
      act       = (i < len);
      start     = act && (i == 0 || i == restart_off);
      stop      = act && (i == stop_off);
      cen       = act && ((cen_per == 0) ? ($urandom_range(0, 1) == 1) : ((i % cen_per) == 0));
      host_wr   = act && (i == host_off || (rand_host && i > 0 && $urandom_range(0, 5) == 0));
      host_addr = 4'($urandom_range(0, 15));
      host_din  = 8'($urandom_range(0, 255));
      if (i == host_off) begin
        host_addr = 4'h7;
        host_din  = 8'h31;
      end
      tick();
    end
    e      = s + len + TAIL - 1;
    stop_c = (stop_off >= 0) ? s + stop_off : MAXC;
    model(s, e, stop_c);
    for (int c = s; c <= e; c++) begin
      if (ew[c] || ow[c]) begin
        check($sformatf("%s strobe@+%0d", name, c - s), 32'(ow[c]), 32'(ew[c]));
        if (ew[c] && ow[c])
          check($sformatf("%s data@+%0d", name, c - s), 32'(ov[c]), 32'(ev[c]));
      end
      if (ed[c] || od[c]) begin
        check($sformatf("%s done@+%0d", name, c - s), 32'(od[c]), 32'(ed[c]));
        if (od[c]) check($sformatf("%s busy_fall@+%0d", name, c - s), {30'd0, ob[c-1], ob[c]}, 32'b10);
      end
    end
    check($sformatf("%s busy_after_start", name), 32'(ob[s+1]), 32'(stop_off != 0));
    if (stop_off >= 0) check($sformatf("%s busy_after_stop", name), 32'(ob[s+stop_off+1]), 32'd0);
    check($sformatf("%s busy_at_end", name), 32'(ob[e]), 32'd0);
  endtask

  task automatic load_list(input logic [11:0] c0, input logic [11:0] c1, input logic [11:0] c2);
    for (int i = 0; i < N; i++) mem[i] = 12'hE00;
    mem[0] = c0;
    mem[1] = c1;
    mem[2] = c2;
  endtask

  initial begin
    int lows, nent, op, arg;
    for (int i = 0; i < N; i++) mem[i] = 12'hE00;

    // Reset values
    repeat (3) tick();
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst cmd_addr", 32'(cmd_addr), 32'd0);
    check("rst psg_wr_n", 32'(psg_wr_n), 32'd1);
    check("rst psg_cs_n", 32'(psg_cs_n), 32'd1);
    check("rst psg_addr", 32'(psg_addr), 32'd0);
    check("rst psg_din", 32'(psg_din), 32'd0);
    rst_n = 1'b1;
    tick();

    load_list(12'h001, 12'h100, 12'hE00);
    run_window("list1", 14, 1, -1, -1, 1'b0, -1);

    load_list(12'hF02, 12'h810, 12'hE00);
    run_window("wait", 60, 4, -1, -1, 1'b0, -1);

    load_list(12'h0AA, 12'h1BB, 12'hE00);
    run_window("collide", 14, 1, -1, 2, 1'b0, -1);

    load_list(12'hFFF, 12'h001, 12'hE00);
    run_window("stop", 110, 1, 100, -1, 1'b0, -1);

    load_list(12'h001, 12'h100, 12'hE00);
    run_window("restart", 14, 1, -1, -1, 1'b0, -1);
    run_window("stopstart", 8, 1, 0, 3, 1'b0, -1);

    for (int i = 0; i < N; i++) mem[i] = 12'h055;
    run_window("fill", 136, 1, -1, -1, 1'b0, 20);
    check("fill cmd_addr_end", 32'(cmd_addr), 32'(N - 1));

    // Reset for one clk in the middle of a write list
    start = 1'b1;
    cen   = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst done", 32'(done), 32'd0);
    check("midrst cmd_addr", 32'(cmd_addr), 32'd0);
    check("midrst psg_wr_n", 32'(psg_wr_n), 32'd1);
    check("midrst psg_cs_n", 32'(psg_cs_n), 32'd1);
    check("midrst psg_addr", 32'(psg_addr), 32'd0);
    check("midrst psg_din", 32'(psg_din), 32'd0);
    lows = 0;
    repeat (20) begin
      tick();
      if (!psg_wr_n) lows++;
    end
    check("midrst no_writes", 32'(lows), 32'd0);
    cen = 1'b0;

    // Randomized lists with random cen and host traffic
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N; i++) mem[i] = 12'hE00;
      nent = $urandom_range(4, 12);
      for (int i = 0; i < nent; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          arg    = $urandom_range(0, 3);
          mem[i] = {4'hF, 8'(arg)};
        end else begin
          op     = $urandom_range(0, 13);
          arg    = $urandom_range(0, 255);
          mem[i] = {4'(op), 8'(arg)};
        end
      end
      run_window($sformatf("rand%0d", r), 600, 0, -1, -1, 1'b1, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
